// File: rtl/icache_sram_nway_if.sv
// Request/response bundle between the I-cache controller and its N-way storage array.
interface icache_sram_nway_if #(
   parameter int TAG_W      = 22,
   parameter int IDX_W      = 5,
   parameter int BLOCK_BITS = 256
);
   logic                    ren;
   logic                    memWen;
   logic                    flush;
   logic [TAG_W+IDX_W-1:0]  blockAddr;
   logic [BLOCK_BITS-1:0]   dataIn;
   logic                    hit;
   logic [BLOCK_BITS-1:0]   dataOut;
   logic                    busy;

   modport master (
      output ren, memWen, flush, blockAddr, dataIn,
      input  hit, dataOut, busy
   );

   modport slave (
      input  ren, memWen, flush, blockAddr, dataIn,
      output hit, dataOut, busy
   );
endinterface

// File: rtl/icache_sram_nway.sv
// N-way set-associative I-cache tag/valid/data storage with internal victim choice and flush sweep.
// ICACHE_LRU_EN selects true-LRU ages; otherwise a per-set round-robin pointer picks victims.
module icache_sram_nway #(
   parameter int TAG_W      = 22,
   parameter int IDX_W      = 5,
   parameter int BLOCK_BITS = 256,
   parameter int WAYS       = 4
) (
   input  logic                clk,
   input  logic                rst,
   icache_sram_nway_if.slave   bus
);
   localparam int WAY_W = $clog2(WAYS);
   localparam int SETS  = 1 << IDX_W;

   typedef enum logic {IDLE, SWEEP} state_t;
   state_t state, state_nxt;

   logic [IDX_W-1:0]      sweep_cnt;
   logic                  busy_c;
   logic                  sweep_clr;

   logic [TAG_W-1:0]      tag_arr  [SETS][WAYS];
   logic [BLOCK_BITS-1:0] data_arr [SETS][WAYS];
   logic [WAYS-1:0]       valid_q  [SETS];

   logic [IDX_W-1:0]      idx;
   logic [TAG_W-1:0]      tag;
   logic                  do_fill;
   logic                  do_lookup;

   logic [WAYS-1:0]       match;
   logic [WAYS-1:0]       invalid;
   logic                  hit_any;
   logic                  inv_any;
   logic [WAY_W-1:0]      hit_way;
   logic [WAY_W-1:0]      inv_way;
   logic [WAY_W-1:0]      victim;
   logic [WAY_W-1:0]      fill_way;
   logic [BLOCK_BITS-1:0] hit_data;

   logic                  hit_p1;
   logic [BLOCK_BITS-1:0] data_p1;

   assign idx       = bus.blockAddr[IDX_W-1:0];
   assign tag       = bus.blockAddr[TAG_W+IDX_W-1:IDX_W];
   assign do_fill   = bus.memWen & ~bus.flush & ~busy_c;
   assign do_lookup = bus.ren & ~bus.memWen & ~bus.flush & ~busy_c;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= IDLE;
      else      state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      busy_c    = 1'b0;
      sweep_clr = 1'b0;
      case (state)
         IDLE: begin
            if (bus.flush) state_nxt = SWEEP;
         end
         SWEEP: begin
            busy_c    = 1'b1;
            sweep_clr = 1'b1;
            if (&sweep_cnt) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   assign bus.busy = busy_c;

   // Counter wraps back to 0 on the same edge the sweep clears the last set.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)           sweep_cnt <= '0;
      else if (sweep_clr) sweep_cnt <= sweep_cnt + 1'b1;
   end

   always_comb begin
      match    = '0;
      invalid  = '0;
      hit_way  = '0;
      inv_way  = '0;
      for (int w = 0; w < WAYS; w++) begin
         match[w]   = valid_q[idx][w] && (tag_arr[idx][w] == tag);
         invalid[w] = ~valid_q[idx][w];
      end
      for (int w = WAYS - 1; w >= 0; w--) begin
         if (match[w])   hit_way = WAY_W'(w);
         if (invalid[w]) inv_way = WAY_W'(w);
      end
      hit_data = data_arr[idx][hit_way];
   end

   assign hit_any  = |match;
   assign inv_any  = |invalid;
   assign fill_way = hit_any ? hit_way : (inv_any ? inv_way : victim);

`ifdef ICACHE_LRU_EN
   logic [WAY_W-1:0] age_q   [SETS][WAYS];
   logic [WAY_W-1:0] age_nxt [WAYS];
   logic [WAY_W-1:0] acc_way;
   logic [WAY_W-1:0] acc_age;

   assign acc_way = do_fill ? fill_way : hit_way;

   // Ages form a permutation: touched way becomes 0, younger ways shift up by one.
   always_comb begin
      victim  = '0;
      acc_age = age_q[idx][acc_way];
      for (int w = 0; w < WAYS; w++) begin
         age_nxt[w] = age_q[idx][w];
         if (age_q[idx][w] == WAY_W'(WAYS - 1)) victim = WAY_W'(w);
         if (WAY_W'(w) == acc_way)            age_nxt[w] = '0;
         else if (age_q[idx][w] < acc_age)    age_nxt[w] = age_q[idx][w] + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int s = 0; s < SETS; s++)
            for (int w = 0; w < WAYS; w++)
               age_q[s][w] <= WAY_W'(w);
      end else if (sweep_clr) begin
         for (int w = 0; w < WAYS; w++) age_q[sweep_cnt][w] <= WAY_W'(w);
      end else if (do_fill || (do_lookup && hit_any)) begin
         for (int w = 0; w < WAYS; w++) age_q[idx][w] <= age_nxt[w];
      end
   end
`else
   logic [WAY_W-1:0] rr_ptr [SETS];

   assign victim = rr_ptr[idx];

   // Only allocating fills advance the pointer; refreshes and read hits leave it alone.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int s = 0; s < SETS; s++) rr_ptr[s] <= '0;
      end else if (sweep_clr) begin
         rr_ptr[sweep_cnt] <= '0;
      end else if (do_fill && !hit_any) begin
         rr_ptr[idx] <= rr_ptr[idx] + 1'b1;
      end
   end
`endif

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int s = 0; s < SETS; s++) valid_q[s] <= '0;
      end else if (sweep_clr) begin
         valid_q[sweep_cnt] <= '0;
      end else if (do_fill) begin
         valid_q[idx][fill_way] <= 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (do_fill) begin
         tag_arr[idx][fill_way]  <= tag;
         data_arr[idx][fill_way] <= bus.dataIn;
      end
   end

   // Stage p1: registered lookup result, cleared on every non-hitting cycle.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         hit_p1  <= 1'b0;
         data_p1 <= '0;
      end else begin
         hit_p1  <= do_lookup & hit_any;
         data_p1 <= (do_lookup & hit_any) ? hit_data : '0;
      end
   end

   assign bus.hit     = hit_p1;
   assign bus.dataOut = data_p1;
endmodule

// File: tb/tb_icache_sram_nway.sv
// Bench for icache_sram_nway: directed vector table, flush/reset sequences, random traffic vs a recency model.
module tb_icache_sram_nway;
   localparam int TAG_W = 22;
   localparam int IDX_W = 5;
   localparam int BB    = 256;
   localparam int WAYS  = 4;
   localparam int SETS  = 1 << IDX_W;
`ifdef ICACHE_LRU_EN
   localparam bit LRU = 1'b1;
`else
   localparam bit LRU = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   icache_sram_nway_if #(.TAG_W(TAG_W), .IDX_W(IDX_W), .BLOCK_BITS(BB)) bus ();

   icache_sram_nway #(.TAG_W(TAG_W), .IDX_W(IDX_W), .BLOCK_BITS(BB), .WAYS(WAYS)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   int total = 0;
   int bad   = 0;

   task automatic chk(string name, logic [BB-1:0] got, logic [BB-1:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %h required %h", name, got, exp);
      end
   endtask

   // Reference model: per-way contents plus last-use timestamps (LRU) or a rotating pointer.
   bit            m_val [SETS][WAYS];
   int            m_tag [SETS][WAYS];
   logic [BB-1:0] m_dat [SETS][WAYS];
   longint        m_use [SETS][WAYS];
   int            m_ptr [SETS];
   longint        now = 0;
   int            m_busy = 0;
   logic          m_hit;
   logic [BB-1:0] m_out;

   function automatic void m_clear();
      for (int s = 0; s < SETS; s++) begin
         m_ptr[s] = 0;
         for (int w = 0; w < WAYS; w++) begin
            m_val[s][w] = 1'b0;
            m_use[s][w] = -longint'(w);
         end
      end
   endfunction

   function automatic int m_find(int s, int t);
      for (int w = 0; w < WAYS; w++)
         if (m_val[s][w] && m_tag[s][w] == t) return w;
      return -1;
   endfunction

   function automatic void m_touch(int s, int w);
      now++;
      m_use[s][w] = now;
   endfunction

   function automatic void m_fill(int s, int t, logic [BB-1:0] d);
      int w;
      bit alloc;
      w = m_find(s, t);
      alloc = (w < 0);
      if (w < 0)
         for (int i = WAYS - 1; i >= 0; i--) if (!m_val[s][i]) w = i;
      if (w < 0) begin
         if (LRU) begin
            w = 0;
            for (int i = 1; i < WAYS; i++) if (m_use[s][i] < m_use[s][w]) w = i;
         end else begin
            w = m_ptr[s];
         end
      end
      m_val[s][w] = 1'b1;
      m_tag[s][w] = t;
      m_dat[s][w] = d;
      m_touch(s, w);
      if (alloc) m_ptr[s] = (m_ptr[s] + 1) % WAYS;
   endfunction

   task automatic cyc(bit r, bit mw, bit fl, int t, int s, logic [BB-1:0] d);
      int w;
      bus.ren       = r;
      bus.memWen    = mw;
      bus.flush     = fl;
      bus.blockAddr = {TAG_W'(t), IDX_W'(s)};
      bus.dataIn    = d;
      @(posedge clk);
      m_hit = 1'b0;
      m_out = '0;
      if (m_busy > 0) m_busy--;
      else if (fl) begin
         m_clear();
         m_busy = SETS;
      end else if (mw) m_fill(s, t, d);
      else if (r) begin
         w = m_find(s, t);
         if (w >= 0) begin
            m_hit = 1'b1;
            m_out = m_dat[s][w];
            m_touch(s, w);
         end
      end
      #1;
      bus.ren    = 1'b0;
      bus.memWen = 1'b0;
      bus.flush  = 1'b0;
   endtask

   task automatic chk_model(string n);
      chk({n, ".hit"},  bus.hit,     m_hit);
      chk({n, ".data"}, bus.dataOut, m_out);
      chk({n, ".busy"}, bus.busy,    (m_busy > 0));
   endtask

   function automatic logic [BB-1:0] rep(logic [7:0] b);
      return {32{b}};
   endfunction

   typedef struct {
      bit            r;
      bit            mw;
      int            t;
      int            s;
      logic [BB-1:0] d;
      bit            eh;
      logic [BB-1:0] ed;
   } vec_t;
   vec_t tbl[$];

   function automatic void add(bit r, bit mw, int t, int s, logic [BB-1:0] d, bit eh, logic [BB-1:0] ed);
      vec_t v;
      v.r = r; v.mw = mw; v.t = t; v.s = s; v.d = d; v.eh = eh; v.ed = ed;
      tbl.push_back(v);
   endfunction

   task automatic do_reset();
      rst = 1'b0;
      bus.ren = 1'b0; bus.memWen = 1'b0; bus.flush = 1'b0;
      bus.blockAddr = '0; bus.dataIn = '0;
      repeat (2) @(posedge clk);
      m_clear();
      m_busy = 0;
      @(negedge clk);
      rst = 1'b1;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "timeout");
   end

   initial begin
      int busy_len;
      logic [BB-1:0] rd;

      add(1, 0, 0, 0, '0,        0, '0);
      add(0, 1, 1, 0, rep(8'h11), 0, '0);
      add(0, 1, 2, 0, rep(8'h22), 0, '0);
      add(0, 1, 3, 0, rep(8'h33), 0, '0);
      add(0, 1, 4, 0, rep(8'h44), 0, '0);
      add(1, 0, 3, 0, '0,        1, rep(8'h33));
      add(1, 0, 5, 0, '0,        0, '0);
      add(1, 0, 1, 0, '0,        1, rep(8'h11));
      add(0, 1, 5, 0, rep(8'h55), 0, '0);
      add(1, 0, 2, 0, '0,        !LRU, LRU ? '0 : rep(8'h22));
      add(1, 0, 1, 0, '0,        LRU, LRU ? rep(8'h11) : '0);
      add(1, 0, 3, 0, '0,        1, rep(8'h33));
      add(1, 0, 4, 0, '0,        1, rep(8'h44));
      add(1, 0, 5, 0, '0,        1, rep(8'h55));
      add(0, 1, 3, 0, rep(8'hAA), 0, '0);
      add(1, 0, 3, 0, '0,        1, rep(8'hAA));
      add(1, 0, 4, 0, '0,        1, rep(8'h44));
      add(1, 0, 5, 0, '0,        1, rep(8'h55));
      add(1, 0, LRU ? 1 : 2, 0, '0, 1, LRU ? rep(8'h11) : rep(8'h22));
      add(1, 1, 7, 0, rep(8'h77), 0, '0);
      add(1, 0, 7, 0, '0,        1, rep(8'h77));
      add(0, 0, 7, 0, '0,        0, '0);
      add(0, 1, 9, 31, rep(8'h99), 0, '0);
      add(1, 0, 9, 31, '0,       1, rep(8'h99));
      add(1, 0, 9, 30, '0,       0, '0);

      do_reset();
      #1;
      chk("reset.hit",  bus.hit,     1'b0);
      chk("reset.data", bus.dataOut, '0);
      chk("reset.busy", bus.busy,    1'b0);

      for (int i = 0; i < tbl.size(); i++) begin
         cyc(tbl[i].r, tbl[i].mw, 1'b0, tbl[i].t, tbl[i].s, tbl[i].d);
         chk($sformatf("vec%0d.hit", i),  bus.hit,     tbl[i].eh);
         chk($sformatf("vec%0d.data", i), bus.dataOut, tbl[i].ed);
         chk($sformatf("vec%0d.busy", i), bus.busy,    1'b0);
      end

      // Flush: busy length, ignored requests during the sweep, everything misses afterwards.
      cyc(0, 0, 1, 0, 0, '0);
      chk("flush.busy_start", bus.busy, 1'b1);
      busy_len = 1;
      for (int k = 0; k < 40; k++) begin
         cyc(1, (k == 10), (k == 5), (k == 10) ? 33 : 3, 0, rep(8'hF0));
         chk_model($sformatf("sweep%0d", k));
         if (bus.busy) busy_len++;
      end
      chk("flush.busy_len", busy_len, 32);
      foreach (tbl[i]) begin
         if (tbl[i].mw) begin
            cyc(1, 0, 0, tbl[i].t, tbl[i].s, '0);
            chk($sformatf("postflush.t%0d_s%0d", tbl[i].t, tbl[i].s), bus.hit, 1'b0);
         end
      end
      cyc(1, 0, 0, 33, 0, '0);
      chk("postflush.ignored_fill", bus.hit, 1'b0);

      // Random traffic on a few sets and tags so refreshes, evictions and flushes all occur.
      for (int n = 0; n < 700; n++) begin
         int op, t, s;
         op = $urandom_range(0, 199);
         t  = $urandom_range(1, 6);
         s  = ($urandom_range(0, 9) == 0) ? 31 : $urandom_range(0, 2);
         for (int j = 0; j < 8; j++) rd[j*32 +: 32] = $urandom;
         if (op < 2)        cyc(0, 0, 1, t, s, rd);
         else if (op < 80)  cyc(0, 1, 0, t, s, rd);
         else if (op < 90)  cyc(1, 1, 0, t, s, rd);
         else if (op < 185) cyc(1, 0, 0, t, s, rd);
         else               cyc(0, 0, 0, t, s, rd);
         chk_model($sformatf("rand%0d", n));
      end
      while (m_busy > 0) begin
         cyc(0, 0, 0, 0, 0, '0);
         chk_model("drain");
      end

      // Reset pulled low mid-sweep drops busy at once.
      cyc(0, 1, 0, 2, 1, rep(8'h5A));
      cyc(0, 0, 1, 0, 0, '0);
      for (int k = 0; k < 10; k++) begin
         cyc(1, 0, 0, 2, 1, '0);
         chk_model($sformatf("presweep%0d", k));
      end
      #2;
      rst = 1'b0;
      #1;
      chk("midreset.busy", bus.busy,    1'b0);
      chk("midreset.hit",  bus.hit,     1'b0);
      chk("midreset.data", bus.dataOut, '0);
      m_clear();
      m_busy = 0;
      @(negedge clk);
      rst = 1'b1;
      for (int k = 0; k < 3; k++) begin
         cyc(1, 0, 0, 2, 1, '0);
         chk_model($sformatf("postreset%0d", k));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/icache_sram_nway.md
# icache_sram_nway

Parametrised N-way set-associative instruction-cache storage array: tag, valid and data arrays with per-set replacement state and a flush sweep. Successor to the fixed 2-way I-cache SRAM. Sits between the I-cache controller (read lookups, fills from memory) and nothing below. It answers hit/data one cycle after a lookup and chooses the victim way internally on fills.

## Interface
- TAG_W, 22: tag width in bits.
- IDX_W, 5: set-index width; 2^IDX_W sets.
- BLOCK_BITS, 256: block width in bits.
- WAYS, 4: associativity, power of two, 2..8; WAY_W = log2(WAYS).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-low reset.
- ren  in  1  lookup request, sampled at posedge.
- memWen  in  1  fill request (block returned from memory), sampled at posedge.
- flush  in  1  invalidate-all request, sampled at posedge.
- blockAddr  in  TAG_W+IDX_W  {tag, index}; index = low IDX_W bits.
- dataIn  in  BLOCK_BITS  fill data.
- hit  out  1  registered lookup result.
- dataOut  out  BLOCK_BITS  registered hit data; zero on miss or no lookup.
- busy  out  1  flush sweep in progress; all requests ignored.

## Operation
- Priority per cycle: busy > flush > memWen > ren. A lower-priority request sampled together with a higher one is dropped (no retry).
- Lookup (ren=1, memWen=0, flush=0, busy=0): compare tag against all valid ways of the set. Hit: hit=1, dataOut=that way's block; replacement state marks way as MRU. Miss: hit=0, dataOut=0, no state change.
- Fill (memWen=1): way selection in order: (1) valid way whose tag matches -> overwrite (refresh); (2) lowest-index invalid way; (3) replacement victim. Writes tag, data, sets valid, marks way MRU. Fill never drives hit=1; hit/dataOut cleared that cycle.
- LRU state: per set, WAYS age fields of WAY_W bits forming a permutation of 0..WAYS-1. Access to way w with age a: w -> 0; every way with age < a increments; others unchanged. Victim = way with age WAYS-1. Reset/flush value: age(way i)=i.
- Flush: FSM IDLE -> SWEEP. SWEEP walks a set counter 0..2^IDX_W-1, one set per cycle, clearing valid and restoring replacement state; returns to IDLE after the last set. Counter wraps to 0 on exit.
- Tag and data arrays are not reset; only valid bits and replacement state are.

## Timing
- Reset (rst=0, asynchronous): hit=0, dataOut=0, busy=0, FSM=IDLE, all valid=0, ages=way index, sweep counter=0. Reset during SWEEP aborts it; state as above.
- Lookup latency: 1 cycle; hit/dataOut valid after the posedge that sampled ren, held until the next posedge (not sticky). Cycles without a lookup drive hit=0, dataOut=0.
- Fill visible to a lookup sampled on the next posedge (write then read back-to-back hits with new data).
- flush sampled at edge T: busy=1 from T to T+2^IDX_W; busy=0 after edge T+2^IDX_W. Requests sampled while busy=1 are ignored; hit=0 throughout.
- flush while busy: ignored.

## Configuration
- ICACHE_LRU_EN defined: true-LRU age scheme above.
- Undefined: per-set round-robin pointer (WAY_W bits, reset/flush 0). Victim = pointer; pointer increments (wraps at WAYS) only on fills that allocate via step (3) or (2); refresh fills and read hits do not change it. Ports and latency identical.

## Test plan
- Reset, then ren blockAddr=0 -> hit=0, dataOut=0, busy=0.
- Fill set 0 with tags 1,2,3,4 (data 0x11..0x44 replicated), read tag 3 -> next cycle hit=1, dataOut=0x33...; read tag 5 -> hit=0, dataOut=0.
- LRU (ICACHE_LRU_EN): after filling tags 1..4, read tag 1, fill tag 5 -> tag 2 evicted (read miss), tags 1,3,4,5 hit. Without macro: same sequence evicts tag 1.
- Refresh: fill tag 3 with 0xAA.. into full set -> tag 3 reads 0xAA.., no other tag evicted.
- Simultaneous ren+memWen same address (new tag 7) -> hit=0 that cycle; ren next cycle -> hit=1 with fill data.
- flush with IDX_W=5 -> busy high exactly 32 cycles, ren during busy -> hit=0; afterwards every previously filled tag misses; rst pulled low mid-sweep -> busy=0 immediately.
